mem_stage: RTL and testbench

- Memory (M) stage of the 5-stage MIPS pipeline. Consumes the outputs of the E/M pipeline register.
- Holds the word-addressed data memory (DM) with byte/halfword/word store merging, and performs load alignment with sign/zero extension.
- Registers all W-stage fields into the M/W pipeline register.
- Also resolves the store-data forward from the W stage.

---
 rtl/mips_pkg.sv | 12 +
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage_dm.sv | 50 +++++
 rtl/mem_stage.sv | 57 +++++
 tb/tb_mem_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS M stage.
// DMSel access codes, store-data forward select values and the default DM size.
package mips_pkg;
  localparam logic [2:0] DMSEL_W  = 3'd0;
  localparam logic [2:0] DMSEL_HU = 3'd1;
  localparam logic [2:0] DMSEL_H  = 3'd2;
  localparam logic [2:0] DMSEL_BU = 3'd3;
  localparam logic [2:0] DMSEL_B  = 3'd4;
  localparam logic FMUX_V2 = 1'b0;
  localparam logic FMUX_W  = 1'b1;
  localparam int DM_WORDS_DEF = 4096;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: E/M-side inputs and M/W register outputs of the M stage.
// master drives the M_* fields and W_fwd_data and observes W_*.
// slave is the mem_stage side.
interface mem_stage_if;
  logic [31:0] M_Exam_InstrAddr;
  logic        M_DMWE;
  logic        M_GRFWE;
  logic [2:0]  M_DMSel;
  logic [1:0]  M_GRF_WD_W_Sel;
  logic [31:0] M_V2;
  logic [31:0] M_OP;
  logic [4:0]  M_GRF_A3;
  logic [31:0] M_ext32;
  logic [31:0] M_pc8;
  logic        M_FMUX_DM_D_M_Sel;
  logic [31:0] W_fwd_data;
  logic [31:0] W_Exam_InstrAddr;
  logic        W_GRFWE;
  logic [1:0]  W_GRF_WD_W_Sel;
  logic [4:0]  W_GRF_A3;
  logic [31:0] W_OP;
  logic [31:0] W_DMRD;
  logic [31:0] W_ext32;
  logic [31:0] W_pc8;
  modport master (
    output M_Exam_InstrAddr, M_DMWE, M_GRFWE, M_DMSel, M_GRF_WD_W_Sel, M_V2, M_OP,
           M_GRF_A3, M_ext32, M_pc8, M_FMUX_DM_D_M_Sel, W_fwd_data,
    input  W_Exam_InstrAddr, W_GRFWE, W_GRF_WD_W_Sel, W_GRF_A3, W_OP, W_DMRD, W_ext32, W_pc8
  );
  modport slave (
    input  M_Exam_InstrAddr, M_DMWE, M_GRFWE, M_DMSel, M_GRF_WD_W_Sel, M_V2, M_OP,
           M_GRF_A3, M_ext32, M_pc8, M_FMUX_DM_D_M_Sel, W_fwd_data,
    output W_Exam_InstrAddr, W_GRFWE, W_GRF_WD_W_Sel, W_GRF_A3, W_OP, W_DMRD, W_ext32, W_pc8
  );
endinterface

// File: rtl/mem_stage_dm.sv
// dm_core: word-organised data memory with byte-enable store merging.
// Ports: clk, RESET (sync, clears every word), we/sel/addr/wd store request,
// rw = raw word at addr (0 when out of range), combinational.
// Optional DM_WRITE_DISPLAY_EN adds pc input and logs every performed store.
module dm_core import mips_pkg::*; #(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW = 12
) (
  input  logic        clk,
  input  logic        RESET,
`ifdef DM_WRITE_DISPLAY_EN
  input  logic [31:0] pc,
`endif
  input  logic        we,
  input  logic [2:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rw
);
  logic [31:0] mem [DM_WORDS];
  logic [DM_AW-1:0] idx;
  logic in_range, is_b, is_h, is_w, mis, ok;
  logic [3:0] be;
  logic [31:0] wdat, merged;
  assign idx = addr[DM_AW+1:2];
  assign in_range = addr < 32'(4 * DM_WORDS);
  assign rw = in_range ? mem[idx] : '0;
  assign is_b = sel == DMSEL_B || sel == DMSEL_BU;
  assign is_h = sel == DMSEL_H || sel == DMSEL_HU;
  assign is_w = !is_b && !is_h;
  assign mis = (is_w && addr[1:0] != 2'b00) || (is_h && addr[0]);
  assign ok = we && in_range && !mis;
  assign be = is_b ? 4'b0001 << addr[1:0] : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Replicating the sub-word lets each byte lane take its data from the same bit position.
  assign wdat = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
  always_comb begin
    merged = rw;
    for (int i = 0; i < 4; i++) merged[8*i+:8] = be[i] ? wdat[8*i+:8] : rw[8*i+:8];
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (ok) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
`endif
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS M stage - store-data forward mux, data memory, load
// alignment/extension and the M/W pipeline register.
// Ports: clk, RESET (sync, active-high), bus (mem_stage_if.slave).
// Optional macro DM_WRITE_DISPLAY_EN logs performed stores from dm_core.
module mem_stage import mips_pkg::*; #(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW = 12
) (
  input logic clk,
  input logic RESET,
  mem_stage_if.slave bus
);
  logic [31:0] sd, rw, ld;
  logic [7:0] b;
  logic [15:0] h;
  assign sd = bus.M_FMUX_DM_D_M_Sel == FMUX_W ? bus.W_fwd_data : bus.M_V2;
  dm_core #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) u_dm (
    .clk(clk),
    .RESET(RESET),
`ifdef DM_WRITE_DISPLAY_EN
    .pc(bus.M_Exam_InstrAddr),
`endif
    .we(bus.M_DMWE),
    .sel(bus.M_DMSel),
    .addr(bus.M_OP),
    .wd(sd),
    .rw(rw)
  );
  assign b = 8'(rw >> {bus.M_OP[1:0], 3'b000});
  assign h = 16'(rw >> {bus.M_OP[1], 4'b0000});
  always_comb
    ld = bus.M_DMSel == DMSEL_HU ? {16'b0, h} :
         bus.M_DMSel == DMSEL_H  ? {{16{h[15]}}, h} :
         bus.M_DMSel == DMSEL_BU ? {24'b0, b} :
         bus.M_DMSel == DMSEL_B  ? {{24{b[7]}}, b} : rw;
  always_ff @(posedge clk) begin
    if (RESET) begin
      bus.W_Exam_InstrAddr <= '0;
      bus.W_GRFWE <= 1'b0;
      bus.W_GRF_WD_W_Sel <= '0;
      bus.W_GRF_A3 <= '0;
      bus.W_OP <= '0;
      bus.W_DMRD <= '0;
      bus.W_ext32 <= '0;
      bus.W_pc8 <= '0;
    end else begin
      bus.W_Exam_InstrAddr <= bus.M_Exam_InstrAddr;
      bus.W_GRFWE <= bus.M_GRFWE;
      bus.W_GRF_WD_W_Sel <= bus.M_GRF_WD_W_Sel;
      bus.W_GRF_A3 <= bus.M_GRF_A3;
      bus.W_OP <= bus.M_OP;
      bus.W_DMRD <= ld;
      bus.W_ext32 <= bus.M_ext32;
      bus.W_pc8 <= bus.M_pc8;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage against a byte-addressed reference memory.
module tb_mem_stage;
  localparam logic [31:0] LIM = 32'h4000;
  typedef struct packed {
    logic [31:0] ia;
    logic        grfwe;
    logic [1:0]  wdsel;
    logic [4:0]  a3;
    logic [31:0] op;
    logic [31:0] dmrd;
    logic [31:0] ext;
    logic [31:0] pc8;
  } wst_t;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  mem_stage_if m();
  mem_stage #(.DM_WORDS(4096), .DM_AW(12)) dut (.clk(clk), .RESET(RESET), .bus(m));
  always #5 clk = ~clk;
  logic [7:0] mdm [logic [31:0]];
  wst_t exq [$];
  string nmq [$];
  int checks = 0;
  int failures = 0;
  bit use_f = 0;
  logic [31:0] f_pc8;
  logic [4:0] f_a3;
  logic f_grfwe;
  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < LIM && mdm.exists(a)) ? mdm[a] : 8'h00;
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sel);
    logic [31:0] ab, hb, w;
    logic [15:0] hw;
    logic [7:0] bt;
    ab = {a[31:2], 2'b00};
    hb = {a[31:1], 1'b0};
    w = {rb(ab + 3), rb(ab + 2), rb(ab + 1), rb(ab)};
    hw = {rb(hb + 1), rb(hb)};
    bt = rb(a);
    case (sel)
      3'd1: return {16'h0, hw};
      3'd2: return {{16{hw[15]}}, hw};
      3'd3: return {24'h0, bt};
      3'd4: return {{24{bt[7]}}, bt};
      default: return w;
    endcase
  endfunction
  task automatic model_store(input logic [31:0] a, input logic [2:0] sel, input logic [31:0] sd);
    if (a >= LIM) return;
    case (sel)
      3'd1, 3'd2: if (!a[0]) begin mdm[a] = sd[7:0]; mdm[a + 1] = sd[15:8]; end
      3'd3, 3'd4: mdm[a] = sd[7:0];
      default: if (a[1:0] == 2'b00) for (int i = 0; i < 4; i++) mdm[a + i] = sd[8*i+:8];
    endcase
  endtask
  task automatic cyc(input bit r, input bit we, input logic [2:0] sel, input logic [31:0] op,
                     input logic [31:0] v2, input bit fs, input logic [31:0] fwd, input string nm);
    wst_t e;
    @(negedge clk);
    RESET = r;
    m.M_DMWE = we;
    m.M_DMSel = sel;
    m.M_OP = op;
    m.M_V2 = v2;
    m.M_FMUX_DM_D_M_Sel = fs;
    m.W_fwd_data = fwd;
    m.M_Exam_InstrAddr = $urandom;
    m.M_GRFWE = use_f ? f_grfwe : 1'($urandom);
    m.M_GRF_WD_W_Sel = 2'($urandom);
    m.M_GRF_A3 = use_f ? f_a3 : 5'($urandom);
    m.M_ext32 = $urandom;
    m.M_pc8 = use_f ? f_pc8 : $urandom;
    e = '0;
    if (!r) begin
      e.ia = m.M_Exam_InstrAddr;
      e.grfwe = m.M_GRFWE;
      e.wdsel = m.M_GRF_WD_W_Sel;
      e.a3 = m.M_GRF_A3;
      e.op = op;
      e.dmrd = model_load(op, sel);
      e.ext = m.M_ext32;
      e.pc8 = m.M_pc8;
    end
    if (r) mdm.delete();
    else if (we) model_store(op, sel, fs ? fwd : v2);
    exq.push_back(e);
    nmq.push_back(nm);
  endtask
  always @(posedge clk) begin
    wst_t e, g;
    string nm;
    #1;
    if (exq.size() != 0) begin
      e = exq.pop_front();
      nm = nmq.pop_front();
      g = {m.W_Exam_InstrAddr, m.W_GRFWE, m.W_GRF_WD_W_Sel, m.W_GRF_A3, m.W_OP, m.W_DMRD, m.W_ext32, m.W_pc8};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s: dmrd got %h want %h, op got %h want %h, pc8 got %h want %h, a3 got %0d want %0d, all got %h want %h",
                 nm, g.dmrd, e.dmrd, g.op, e.op, g.pc8, e.pc8, g.a3, e.a3, g, e);
      end
    end
  end
  initial begin
    m.M_DMWE = 0; m.M_DMSel = 0; m.M_OP = 0; m.M_V2 = 0; m.M_FMUX_DM_D_M_Sel = 0;
    m.W_fwd_data = 0; m.M_Exam_InstrAddr = 0; m.M_GRFWE = 0; m.M_GRF_WD_W_Sel = 0;
    m.M_GRF_A3 = 0; m.M_ext32 = 0; m.M_pc8 = 0;
    cyc(1, 0, 0, 32'h0, 0, 0, 0, "reset_zero");
    cyc(0, 1, 0, 32'h10, 32'h11223344, 0, 32'hDEADBEEF, "sw_10");
    cyc(0, 0, 0, 32'h10, 0, 0, 0, "lw_10");
    cyc(0, 1, 4, 32'h13, 32'h000000AB, 0, 0, "sb_13");
    cyc(0, 1, 2, 32'h10, 32'h0000BEEF, 0, 0, "sh_10");
    cyc(0, 0, 0, 32'h10, 0, 0, 0, "lw_merged");
    cyc(0, 0, 4, 32'h13, 0, 0, 0, "lb_13");
    cyc(0, 0, 3, 32'h13, 0, 0, 0, "lbu_13");
    cyc(0, 0, 2, 32'h10, 0, 0, 0, "lh_10");
    cyc(0, 0, 1, 32'h12, 0, 0, 0, "lhu_12");
    cyc(0, 1, 0, 32'h20, 32'h0, 1, 32'hCAFEF00D, "sw_fwd");
    cyc(0, 0, 0, 32'h20, 0, 0, 32'h12345678, "lw_fwd");
    cyc(0, 1, 0, 32'h3FFC, 32'h5A5AA5A5, 0, 0, "sw_last");
    cyc(0, 0, 0, 32'h3FFC, 0, 0, 0, "lw_last");
    cyc(0, 1, 0, 32'h4000, 32'h77777777, 0, 0, "sw_oor");
    cyc(0, 0, 0, 32'h4000, 0, 0, 0, "lw_oor");
    cyc(0, 1, 0, 32'h22, 32'h99999999, 0, 0, "sw_misaligned");
    cyc(0, 1, 2, 32'h21, 32'h88888888, 0, 0, "sh_misaligned");
    cyc(0, 0, 0, 32'h20, 0, 0, 0, "lw_after_mis");
    cyc(0, 0, 2, 32'h23, 0, 0, 0, "lh_mis");
    cyc(1, 1, 0, 32'h20, 32'h13572468, 0, 0, "reset_with_sw");
    use_f = 1; f_pc8 = 32'h3008; f_a3 = 5'd31; f_grfwe = 1'b1;
    cyc(0, 0, 0, 32'h20, 0, 0, 0, "lw_after_reset");
    use_f = 0;
    for (int i = 0; i < 600; i++) begin
      bit r, we, fs;
      logic [2:0] sel;
      logic [31:0] op;
      int k;
      r = $urandom_range(0, 59) == 0;
      we = $urandom_range(0, 2) == 0;
      sel = we ? 3'(2 * $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      op = k < 7 ? 32'($urandom_range(0, 63)) :
           k == 7 ? 32'h3FF0 + 32'($urandom_range(0, 15)) :
           k == 8 ? 32'h4000 + 32'($urandom_range(0, 7)) : $urandom;
      fs = 1'($urandom);
      cyc(r, we, sel, op, $urandom, fs, $urandom, "random");
    end
    @(posedge clk);
    #2;
    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL drain: pending got %0d want 0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
